// File: rtl/pe_dbuf_mac.sv
// Weight-stationary systolic PE with a double-buffered weight (daisy-chained shadow, broadcast
// swap), valid-qualified activation/psum paths, signed/unsigned MAC, saturation and sticky ovf.
module pe_dbuf_mac #(
  parameter int unsigned D_W    = 8,
  parameter int unsigned A_W    = 24,
  parameter bit          SIGNED = 1'b1,
  parameter bit          SAT    = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [D_W-1:0] left_in,
  input  logic           left_valid,
  output logic [D_W-1:0] right_out,
  output logic           right_valid,
  input  logic [D_W-1:0] weight_in,
  input  logic           w_shift,
  input  logic           w_swap,
  output logic [D_W-1:0] weight_out,
  input  logic [A_W-1:0] psum_in,
  input  logic           psum_valid_in,
  output logic [A_W-1:0] psum_out,
  output logic           psum_valid_out,
  input  logic           ovf_clr,
  output logic           ovf
);

  localparam int unsigned PW  = 2 * D_W;
  localparam int unsigned EXT = A_W + 1 - PW;

  logic [D_W-1:0] r_right;
  logic           r_right_valid;
  logic [D_W-1:0] r_shadow;
  logic [D_W-1:0] r_active;
  logic [A_W-1:0] r_psum;
  logic           r_psum_valid;
  logic           r_ovf;

  logic [PW-1:0]  w_a_x;
  logic [PW-1:0]  w_w_x;
  logic [PW-1:0]  w_prod;
  logic [A_W:0]   w_prod_x;
  logic [A_W-1:0] w_add;
  logic [A_W:0]   w_add_x;
  logic [A_W:0]   w_sum;
  logic           w_ovf;
  logic [A_W-1:0] w_sat_val;
  logic [A_W-1:0] w_mac;

  // Operands are extended to PW bits first, so the low PW bits of the product are exact
  // for both signed and unsigned operation.
  always_comb begin
    w_a_x    = {{D_W{SIGNED & left_in[D_W-1]}}, left_in};
    w_w_x    = {{D_W{SIGNED & r_active[D_W-1]}}, r_active};
    w_prod   = w_a_x * w_w_x;
    w_prod_x = {{EXT{SIGNED & w_prod[PW-1]}}, w_prod};
    w_add    = psum_valid_in ? psum_in : '0;
    w_add_x  = {SIGNED & w_add[A_W-1], w_add};
    w_sum    = w_add_x + w_prod_x;
    if (SIGNED) begin
      w_ovf     = w_sum[A_W] ^ w_sum[A_W-1];
      w_sat_val = w_sum[A_W] ? {1'b1, {(A_W-1){1'b0}}} : {1'b0, {(A_W-1){1'b1}}};
    end else begin
      w_ovf     = w_sum[A_W];
      w_sat_val = '1;
    end
    w_mac = (SAT && w_ovf) ? w_sat_val : w_sum[A_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_right       <= '0;
      r_right_valid <= 1'b0;
      r_shadow      <= '0;
      r_active      <= '0;
      r_psum        <= '0;
      r_psum_valid  <= 1'b0;
      r_ovf         <= 1'b0;
    end else begin
      r_right       <= left_in;
      r_right_valid <= left_valid;
      if (w_shift) r_shadow <= weight_in;
      // Swap sees the pre-edge shadow, so shift+swap promotes the old value.
      if (w_swap)  r_active <= r_shadow;
      r_psum        <= left_valid ? w_mac : w_add;
      r_psum_valid  <= psum_valid_in | left_valid;
      r_ovf         <= (left_valid & w_ovf) | (r_ovf & ~ovf_clr);
    end
  end

  assign right_out      = r_right;
  assign right_valid    = r_right_valid;
  assign weight_out     = r_shadow;
  assign psum_out       = r_psum;
  assign psum_valid_out = r_psum_valid;
  assign ovf            = r_ovf;

endmodule

// File: tb/tb_pe_dbuf_mac.sv
// Scoreboard bench: three PE variants (signed/sat, signed/wrap, unsigned/sat) share stimulus and
// are checked against an arithmetic reference model; a 4-PE column exercises the shadow chain.
module tb_pe_dbuf_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  left_in, weight_in;
  logic        left_valid, w_shift, w_swap, psum_valid_in, ovf_clr;
  logic [23:0] psum_in;

  logic [7:0]  ro [3];
  logic [7:0]  wo [3];
  logic        rv [3];
  logic        pvo [3];
  logic        ov [3];
  logic [23:0] po [3];

  int n_chk  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pe_dbuf_mac #(
      .D_W   (8),
      .A_W   (24),
      .SIGNED(g != 2),
      .SAT   (g != 1)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .left_in       (left_in),
      .left_valid    (left_valid),
      .right_out     (ro[g]),
      .right_valid   (rv[g]),
      .weight_in     (weight_in),
      .w_shift       (w_shift),
      .w_swap        (w_swap),
      .weight_out    (wo[g]),
      .psum_in       (psum_in),
      .psum_valid_in (psum_valid_in),
      .psum_out      (po[g]),
      .psum_valid_out(pvo[g]),
      .ovf_clr       (ovf_clr),
      .ovf           (ov[g])
    );
  end

  // 4-PE column for the shadow chain
  logic        c_rst, c_lv, c_shift, c_swap, c_pv;
  logic [7:0]  c_left, c_wi;
  logic [23:0] c_pin;
  logic [7:0]  cw [4];
  logic [7:0]  cwin [4];
  logic [23:0] cp [4];
  logic [23:0] cpin [4];
  logic        cpv [4];
  logic        cpvin [4];
  logic [7:0]  cro [4];
  logic        crv [4];
  logic        cov [4];

  always_comb begin
    cwin[0]  = c_wi;
    cpin[0]  = c_pin;
    cpvin[0] = c_pv;
    for (int k = 1; k < 4; k++) begin
      cwin[k]  = cw[k-1];
      cpin[k]  = cp[k-1];
      cpvin[k] = cpv[k-1];
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_col
    pe_dbuf_mac u_pe (
      .clk           (clk),
      .rst           (c_rst),
      .left_in       (c_left),
      .left_valid    (c_lv),
      .right_out     (cro[k]),
      .right_valid   (crv[k]),
      .weight_in     (cwin[k]),
      .w_shift       (c_shift),
      .w_swap        (c_swap),
      .weight_out    (cw[k]),
      .psum_in       (cpin[k]),
      .psum_valid_in (cpvin[k]),
      .psum_out      (cp[k]),
      .psum_valid_out(cpv[k]),
      .ovf_clr       (1'b0),
      .ovf           (cov[k])
    );
  end

  typedef struct packed {
    logic [7:0]  ro;
    logic        rv;
    logic [23:0] po;
    logic        pv;
    logic [7:0]  wo;
    logic        ov;
  } exp_t;
  typedef exp_t [2:0] trio_t;

  trio_t      sb[$];
  logic [7:0] m_sh [3];
  logic [7:0] m_act [3];
  bit         m_ov [3];

  // True-value arithmetic on 64-bit integers, then range check / clamp / wrap.
  function automatic logic [23:0] ref_mac(input bit sg, input bit st, input logic [7:0] a,
                                          input logic [7:0] w, input logic pv,
                                          input logic [23:0] p, output bit ovo);
    longint av, wv, pa, sum, lo, hi;
    if (sg) begin
      av = longint'($signed(a));
      wv = longint'($signed(w));
      pa = pv ? longint'($signed(p)) : 0;
      lo = -(64'sd1 <<< 23);
      hi = (64'sd1 <<< 23) - 1;
    end else begin
      av = longint'(a);
      wv = longint'(w);
      pa = pv ? longint'(p) : 0;
      lo = 0;
      hi = (64'sd1 <<< 24) - 1;
    end
    sum = pa + av * wv;
    ovo = (sum < lo) || (sum > hi);
    if (ovo && st) sum = (sum < lo) ? lo : hi;
    return sum[23:0];
  endfunction

  task automatic commit();
    trio_t t;
    for (int i = 0; i < 3; i++) begin
      bit          o;
      logic [23:0] r;
      if (rst) begin
        m_sh[i]  = '0;
        m_act[i] = '0;
        m_ov[i]  = 1'b0;
        t[i]     = '0;
      end else begin
        r = ref_mac(i != 2, i != 1, left_in, m_act[i], psum_valid_in, psum_in, o);
        if (!left_valid) begin
          r = psum_valid_in ? psum_in : 24'd0;
          o = 1'b0;
        end
        m_ov[i] = o | (m_ov[i] & !ovf_clr);
        if (w_swap)  m_act[i] = m_sh[i];
        if (w_shift) m_sh[i] = weight_in;
        t[i].ro = left_in;
        t[i].rv = left_valid;
        t[i].po = r;
        t[i].pv = psum_valid_in | left_valid;
        t[i].wo = m_sh[i];
        t[i].ov = m_ov[i];
      end
    end
    sb.push_back(t);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; left_in = '0; left_valid = 1'b0; weight_in = '0; w_shift = 1'b0;
    w_swap = 1'b0; psum_in = '0; psum_valid_in = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic rand_inputs();
    left_in = 8'($urandom); left_valid = 1'($urandom); weight_in = 8'($urandom);
    w_shift = ($urandom_range(0, 2) == 0); w_swap = ($urandom_range(0, 3) == 0);
    psum_in = 24'($urandom); psum_valid_in = 1'($urandom);
    ovf_clr = ($urandom_range(0, 7) == 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic load_weight(input logic [7:0] w);
    idle(); w_shift = 1'b1; weight_in = w; commit();
    idle(); w_swap = 1'b1; commit();
  endtask

  // Monitor: every cycle with an outstanding expectation, compare all three DUTs.
  initial begin
    forever begin
      trio_t e, a;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
          a[i].ro = ro[i];
          a[i].rv = rv[i];
          a[i].po = po[i];
          a[i].pv = pvo[i];
          a[i].wo = wo[i];
          a[i].ov = ov[i];
          n_chk++;
          if (a[i] !== e[i]) begin
            n_fail++;
            $display("FAIL scoreboard dut%0d t=%0t got ro=%h rv=%b po=%h pv=%b wo=%h ov=%b exp ro=%h rv=%b po=%h pv=%b wo=%h ov=%b",
                     i, $time, a[i].ro, a[i].rv, a[i].po, a[i].pv, a[i].wo, a[i].ov,
                     e[i].ro, e[i].rv, e[i].po, e[i].pv, e[i].wo, e[i].ov);
          end
        end
      end
    end
  end

  initial begin
    idle();
    c_rst = 1'b1; c_lv = 1'b0; c_shift = 1'b0; c_swap = 1'b0; c_pv = 1'b0;
    c_left = '0; c_wi = '0; c_pin = '0;
    @(negedge clk);

    // Reset held with random inputs, then a swap of the cleared shadow.
    repeat (2) begin
      rand_inputs(); rst = 1'b1; commit();
    end
    c_rst = 1'b0;
    idle(); w_swap = 1'b1; left_valid = 1'b1; left_in = 8'($urandom);
    psum_valid_in = 1'b1; psum_in = 24'h012345; commit();

    // Basic MAC: 3*5 + 10.
    load_weight(8'd5);
    idle(); left_in = 8'd3; left_valid = 1'b1; psum_in = 24'd10; psum_valid_in = 1'b1; commit();

    // Double buffer: stream 2 while 7 loads into the shadow, then swap.
    for (int k = 0; k < 6; k++) begin
      idle(); left_in = 8'd2; left_valid = 1'b1;
      weight_in = 8'd7; w_shift = (k == 1); w_swap = (k == 3); commit();
    end
    idle(); w_shift = 1'b1; weight_in = 8'd9; w_swap = 1'b1; commit();
    idle(); left_in = 8'd2; left_valid = 1'b1; commit();

    // Signed corner: -128*-128 + 0x7FF000 overflows the signed range.
    load_weight(8'h80);
    idle(); left_in = 8'h80; left_valid = 1'b1; psum_in = 24'h7FF000; psum_valid_in = 1'b1;
    commit();
    idle(); commit();
    idle(); ovf_clr = 1'b1; commit();
    idle(); commit();

    // Bubbles.
    idle(); psum_valid_in = 1'b1; psum_in = 24'd123; commit();
    load_weight(8'd6);
    idle(); left_valid = 1'b1; left_in = 8'd4; psum_in = 24'd999; commit();
    idle(); psum_in = 24'd77; left_in = 8'd9; commit();

    // Column chain: push 1..4, then a single broadcast swap.
    c_rst = 1'b1; idle(); commit();
    c_rst = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      c_shift = 1'b1; c_wi = 8'(v); idle(); commit();
    end
    c_shift = 1'b0;
    for (int k = 0; k < 4; k++) chk($sformatf("chain_weight_out_pe%0d", k), 32'(cw[k]), 32'(4 - k));
    c_swap = 1'b1; idle(); commit();
    c_swap = 1'b0; c_left = 8'd1; c_lv = 1'b1; c_pin = '0; c_pv = 1'b1;
    repeat (5) begin
      idle(); commit();
    end
    chk("chain_bottom_psum", 32'(cp[3]), 32'd10);
    chk("chain_bottom_valid", 32'(cpv[3]), 32'd1);
    chk("chain_top_psum", 32'(cp[0]), 32'd4);
    c_lv = 1'b0; c_pv = 1'b0;

    // Random traffic including mid-run resets.
    repeat (400) begin
      rand_inputs();
      rst = ($urandom_range(0, 49) == 0);
      commit();
    end
    idle(); commit();
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_dbuf_mac.md
Name: pe_dbuf_mac

Overview:
- Next-generation weight-stationary processing element for the systolic array.
- Adds a double-buffered weight register with a daisy-chained shadow load, so the next tile's weights load while the current tile computes.
- Adds valid qualification on the activation and psum paths, signed/unsigned arithmetic, optional saturation, and a sticky overflow flag.
- Tiles in a 2-D grid: activations flow left to right, weights and psums flow top to bottom.

Parameters:
- D_W, 8, activation/weight width.
- A_W, 24, psum width; A_W >= 2*D_W is required.
- SIGNED, 1: 1 = two's-complement operands and psum; 0 = unsigned.
- SAT, 1: 1 = saturate psum on overflow; 0 = wrap modulo 2^A_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- left_in  in  D_W  activation from west neighbour
- left_valid  in  1  left_in qualifier
- right_out  out  D_W  activation to east neighbour
- right_valid  out  1  right_out qualifier
- weight_in  in  D_W  shadow-chain input from north neighbour or loader
- w_shift  in  1  shift shadow chain (broadcast per column)
- w_swap  in  1  promote shadow weight to active (broadcast per array)
- weight_out  out  D_W  shadow weight to south neighbour
- psum_in  in  A_W  partial sum from north
- psum_valid_in  in  1  psum_in qualifier
- psum_out  out  A_W  partial sum to south
- psum_valid_out  out  1  psum_out qualifier
- ovf_clr  in  1  clear sticky overflow flag
- ovf  out  1  sticky overflow/saturation flag

Behaviour:
- Reset (rst=1 at clk edge): right_out, right_valid, psum_out, psum_valid_out, ovf, shadow weight (weight_out) and active weight all cleared to 0.
  - Reset mid-operation discards both weight buffers and any in-flight result.
  - No output is X after the first reset edge.
- Activation path, latency 1, every cycle regardless of valid:
  - right_out <= left_in; right_valid <= left_valid.
- Shadow chain:
  - w_shift=1: shadow <= weight_in.
  - weight_out is the shadow register output.
  - A column of N PEs loads in N w_shift cycles; the first value pushed ends in the southmost PE.
  - w_shift=0: shadow holds.
- Swap:
  - w_swap=1: active <= shadow (shadow unchanged unless w_shift is also 1).
  - w_shift and w_swap in the same cycle: active takes the old shadow, shadow takes weight_in.
  - The MAC uses the active value registered before the edge; a swap at edge k affects products sampled at edge k+1 onward.
- MAC, latency 1 (registered output):
  - addend = psum_valid_in ? psum_in : 0.
  - left_valid=1: psum_out <= f(addend + left_in*active).
  - left_valid=0: psum_out <= addend (pass-through, no overflow check).
  - psum_valid_out <= psum_valid_in | left_valid.
- Arithmetic:
  - SIGNED=1: product is a 2*D_W-bit signed value, sign-extended to A_W+1; sum computed in A_W+1 bits.
  - SIGNED=0: zero-extend instead of sign-extend.
  - Overflow occurs when the true sum lies outside [-2^(A_W-1), 2^(A_W-1)-1] (signed) or exceeds 2^A_W-1 (unsigned).
  - SAT=1: clamp to the nearest bound.
  - SAT=0: keep the low A_W bits.
- ovf:
  - Set on any MAC overflow (in both SAT modes).
  - Cleared by ovf_clr; set wins if ovf_clr coincides with a new overflow.
  - Cleared only by reset or ovf_clr.
- No backpressure: the block is a fully synchronous pipeline stage, and every input is consumed each cycle.

Test Plan:
- Reset: drive random inputs with rst=1 for 2 cycles -> every output 0 on the cycle after the first reset edge; a w_swap immediately after reset gives active=0, so psum_out=psum_in.
- Basic MAC (D_W=8, A_W=24): w_shift with weight_in=5, then w_swap; then left_in=3, left_valid=1, psum_in=10, psum_valid_in=1 -> next cycle psum_out=25, psum_valid_out=1, right_out=3, right_valid=1.
- Double buffer: active=5, stream left_in=2 every cycle while shifting weight_in=7 -> psum_out uses 5 until the cycle after w_swap, then uses 7.
  - Simultaneous w_shift (weight_in=9) and w_swap -> active=7, weight_out=9.
- Signed saturation, weight=0x80 (-128), left_in=0x80 (-128), psum_in=0x7FF000:
  - SAT=1 -> psum_out=0x7FFFFF, ovf=1.
  - SAT=0 -> psum_out=0x803000, ovf=1.
  - ovf_clr pulse with no new overflow -> ovf=0.
- Bubbles:
  - left_valid=0, psum_valid_in=1, psum_in=123 -> psum_out=123, psum_valid_out=1.
  - left_valid=1, psum_valid_in=0, left_in=4, weight=6 -> psum_out=24.
  - Both valids 0 -> psum_out=0, psum_valid_out=0.
- Chain: 4 PEs in a column, push 1,2,3,4 with w_shift -> weight_out of each PE from top to bottom reads 4,3,2,1 (bottom PE holds 1); one w_swap loads all four active weights in the same cycle.
